mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing one single-port byte memory between requesters, typically the UART command controller (port 0) and a second on-chip client such as a display scanner or CPU (port 1). Accepts at most one access per cycle, drives the memory's read/write strobes, captures read data and returns it to the winning port one cycle later. Fair round-robin arbitration plus burst locking, with an optional lock-timeout guard against starvation.

## Interface
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- LOCK_MAX, 16, maximum consecutive locked grants before forced release (guard builds only; ≥1).

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; valid with req.
- lock0 / lock1  in  1  keep ownership after this grant.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write byte.
- gnt0 / gnt1  out  1  combinational; access accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid, one-cycle pulse.
- rdata0 / rdata1  out  DATA_W  registered read data; holds last value.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write byte.
- mem_rdata  in  DATA_W  combinational read data, valid same cycle as mem_read.

## Operation
- States: IDLE, OWN0, OWN1. Reset → IDLE, last-granted pointer = 1 (port 0 wins first tie), lock counter = 0.
- IDLE: only one req → grant it. Both → grant the port not last granted. Update pointer to winner.
- Winner with lock asserted at grant → OWNn. Otherwise stay IDLE.
- OWNn: only port n granted; other port stalls regardless of req. Each cycle with req_n && gnt_n && lock_n stays OWNn. lock_n low at a grant, or req_n low → IDLE (transaction in that cycle still completes).
- Grant drives mem_read = !we, mem_write = we, mem_addr/mem_wdata from winner. No grant → strobes 0, mem_addr/mem_wdata = 0.
- Read grant: mem_rdata captured into rdata_n at the edge; rvalid_n = 1 for the next cycle only.
- Write: no rvalid. Read of same address on following cycle returns new data.
- Exactly one of gnt0/gnt1 high at most; never both.

## Timing
- Grant: same cycle as req (combinational from req, state, pointer).
- Read latency: rvalid_n one cycle after gnt_n; back-to-back reads give rvalid every cycle.
- Throughput: one access per cycle, no bubbles on port switch.
- Reset: during rst all gnt, mem_read, mem_write forced 0; after edge rvalid0/1 = 0, rdata0/1 = 0, state IDLE. Reset mid-burst drops ownership; a read granted the cycle rst rises produces no rvalid.
- Simultaneous lock release by owner and req by other: other granted next cycle.

## Configuration
- MEM_ARBITER_LOCK_GUARD_EN defined: counter counts grants in OWNn (width clog2(LOCK_MAX+1)). On LOCK_MAX-th grant, force → IDLE, pointer = n, so a pending other port wins next; if other idle, owner may re-acquire. Counter clears on entering IDLE.
- Undefined: no counter; lock held indefinitely; LOCK_MAX ignored.

## Structure
- Package mem_arb_pkg: state encodings (ARB_IDLE, ARB_OWN0, ARB_OWN1), port IDs (PORT0, PORT1).
- Sub-module mem_arb_lock_timer: guard counter with clear/count inputs and expire output; instantiated only under MEM_ARBITER_LOCK_GUARD_EN.

## Test plan
- req0 write 0xA5 @0x0010, then req0 read @0x0010 → gnt0 each cycle, rvalid0 next cycle, rdata0 = 0xA5.
- req0 and req1 reads held 4 cycles after reset → grants alternate 0,1,0,1; rvalid follows each by one cycle.
- req1 lock1 burst writes 0x01..0x05 @0x0100.. with req0 pending → gnt1 ×5, gnt0 first cycle after lock1 drops; memory holds 0x01..0x05.
- Guard build, LOCK_MAX=4, lock0 held with req1 pending → gnt0 ×4, then gnt1, then port 0 resumes; non-guard build → gnt0 indefinitely.
- rst asserted mid-burst (OWN0, read in flight) → gnt0 = 0, rvalid0 = 0, rdata0 = 0 after edge; next req1 granted immediately.
- Idle (no req) → mem_read = mem_write = 0, mem_addr = 0, no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings and port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Lock-timeout counter: counts consecutive locked grants and flags the LOCK_MAX-th one.
module mem_arb_lock_timer #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(LOCK_MAX - 1);

  logic [CW-1:0] cnt;

  // The grant that acquires ownership counts as the first of the run.
  assign expire = count && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst locking sharing a single-port byte memory between two clients.
// Define MEM_ARBITER_LOCK_GUARD_EN to force release of a lock after LOCK_MAX consecutive grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

  arb_state_t state, state_nx;
  port_id_t   last, last_nx;
  logic       g0, g1;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB_IDLE: begin
          if (req0 && req1) begin
            g0 = (last == PORT1);
            g1 = (last == PORT0);
          end else begin
            g0 = req0;
            g1 = req1;
          end
        end
        ARB_OWN0: g0 = req0;
        ARB_OWN1: g1 = req1;
        default: ;
      endcase
    end
  end

`ifdef MEM_ARBITER_LOCK_GUARD_EN
  logic expire;
  logic timer_clear;
  logic timer_count;

  assign timer_count = (g0 && lock0) || (g1 && lock1);
  assign timer_clear = (state_nx == ARB_IDLE);

  mem_arb_lock_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_lock_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .count (timer_count),
    .expire(expire)
  );
`endif

  // Any cycle without a locked grant by the current winner falls back to IDLE.
  always_comb begin
    state_nx = ARB_IDLE;
    last_nx  = last;
    if (g0) begin
      last_nx  = PORT0;
      state_nx = lock0 ? ARB_OWN0 : ARB_IDLE;
    end else if (g1) begin
      last_nx  = PORT1;
      state_nx = lock1 ? ARB_OWN1 : ARB_IDLE;
    end
`ifdef MEM_ARBITER_LOCK_GUARD_EN
    if (expire) begin
      state_nx = ARB_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      last  <= PORT1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  assign gnt0 = g0;
  assign gnt1 = g1;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (g0) begin
      mem_read  = !we0;
      mem_write = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (g1) begin
      mem_read  = !we1;
      mem_write = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= g0 && !we0;
      rvalid1 <= g1 && !we1;
      if (g0 && !we0) begin
        rdata0 <= mem_rdata;
      end
      if (g1 && !we1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule
